// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential or PC-relative branch target, with alignment check.
module pc_next
    import fetch_pkg::*;
(
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] ImmExt,
    input  logic            PCsrc,
    output logic [XLEN-1:0] next_pc,
    output logic            next_misaligned
);

    always_comb begin
        next_pc         = PCsrc ? (PC + ImmExt) : (PC + XLEN'(4));
        next_misaligned = |next_pc[1:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack instruction-memory reads and
// a valid/ready hand-off of the fetched word to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCsrc,
    input  logic [XLEN-1:0] ImmExt,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] PC,
    output logic            misaligned
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            misaligned_q, misaligned_d;
    logic            imem_req_q, imem_req_d;
    logic            instr_valid_q, instr_valid_d;

    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;

    pc_next u_pc_next (
        .PC              (pc_q),
        .ImmExt          (ImmExt),
        .PCsrc           (PCsrc),
        .next_pc         (next_pc),
        .next_misaligned (next_misaligned)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        misaligned_d = misaligned_q;

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Branch inputs only matter on the cycle decode accepts the word
                if (instr_ready) begin
                    if (next_misaligned) begin
                        misaligned_d = 1'b1;
                        state_d      = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = REQ;
                    end
                end
            end
            HALT: state_d = HALT;
        endcase

        // Moore outputs registered from the upcoming state
        imem_req_d    = (state_d == REQ);
        instr_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            misaligned_q  <= 1'b0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            misaligned_q  <= misaligned_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch/branch/stall/halt/reset vectors.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        pcsrc;
    logic [31:0] imm_ext;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic        misaligned;

    logic        b_req;
    logic [31:0] b_addr;
    logic        b_ack;
    logic [31:0] b_rdata;
    logic [31:0] b_instr;
    logic        b_valid;
    logic [31:0] b_pc;
    logic        b_mis;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    int   wait_cnt = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .PCsrc(pcsrc), .ImmExt(imm_ext),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .PC(pc), .misaligned(misaligned)
    );

    // Second instance exercises the PC wrap from the top of the address space
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .PCsrc(1'b0), .ImmExt(32'h0),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_ack),
        .imem_rdata(b_rdata), .instr(b_instr), .instr_valid(b_valid),
        .instr_ready(1'b1), .PC(b_pc), .misaligned(b_mis)
    );

    assign b_ack   = b_req;
    assign b_rdata = 32'hC0DE_0000 | {16'h0, b_addr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] p);
        exp_t e;
        e.pc  = p;
        e.ins = 32'hC0DE_0000 | {16'h0, p[15:0]};
        sb.push_back(e);
    endtask

    // Memory model: address 0x8 answers after 3 wait cycles, all others at once
    always @(negedge clk) begin
        if (imem_req) begin
            if (wait_cnt >= ((imem_addr == 32'h8) ? 3 : 0)) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt   = 0;
            end else begin
                imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            wait_cnt   = 0;
        end
    end

    // Monitor: every accepted instruction must match the next scoreboard entry
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h with empty queue", pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_instr", instr, e.ins);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0000_0013);
        chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, "_req"}, 32'(imem_req), 32'h0);
        chk({tag, "_mis"}, 32'(misaligned), 32'h0);
    endtask

    logic        rq[28];
    logic        vl[28];
    logic        ms[28];
    logic        rd[28];
    logic        ps[28];
    logic [31:0] pv[28];
    logic [31:0] im[28];

    initial begin
        rst = 1'b1; pcsrc = 1'b0; imm_ext = 32'h0; instr_ready = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0;

        // Expected cycle-by-cycle trace after reset release
        for (int k = 0; k < 28; k++) begin
            rd[k] = 1'b1; ps[k] = 1'b0; im[k] = 32'h0; ms[k] = 1'b0;
            case (k)
                0:              begin rq[k] = 1; vl[k] = 0; pv[k] = 32'h00; end
                1:              begin rq[k] = 0; vl[k] = 1; pv[k] = 32'h00; end
                2:              begin rq[k] = 1; vl[k] = 0; pv[k] = 32'h04; end
                3:              begin rq[k] = 0; vl[k] = 1; pv[k] = 32'h04; end
                4, 5, 6, 7:     begin rq[k] = 1; vl[k] = 0; pv[k] = 32'h08; end
                8:              begin rq[k] = 0; vl[k] = 1; pv[k] = 32'h08; end
                9:              begin rq[k] = 1; vl[k] = 0; pv[k] = 32'h0C; end
                10:             begin rq[k] = 0; vl[k] = 1; pv[k] = 32'h0C; end
                11:             begin rq[k] = 1; vl[k] = 0; pv[k] = 32'h10; end
                12, 13, 14, 15: begin rq[k] = 0; vl[k] = 1; pv[k] = 32'h10; rd[k] = 0; end
                16:             begin rq[k] = 0; vl[k] = 1; pv[k] = 32'h10; ps[k] = 1; im[k] = 32'hFFFF_FFF8; end
                17, 18, 19, 20: begin rq[k] = 1; vl[k] = 0; pv[k] = 32'h08; end
                21:             begin rq[k] = 0; vl[k] = 1; pv[k] = 32'h08; ps[k] = 1; im[k] = 32'h18; end
                22:             begin rq[k] = 1; vl[k] = 0; pv[k] = 32'h20; end
                23:             begin rq[k] = 0; vl[k] = 1; pv[k] = 32'h20; ps[k] = 1; im[k] = 32'h6; end
                default:        begin rq[k] = 0; vl[k] = 0; pv[k] = 32'h20; ms[k] = 1; end
            endcase
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        chk("wrap_reset_pc", b_pc, 32'hFFFF_FFFC);

        push(32'h00); push(32'h04); push(32'h08); push(32'h0C);
        push(32'h10); push(32'h08); push(32'h20);
        rst = 1'b0;

        for (int k = 0; k < 28; k++) begin
            @(posedge clk);
            #1;
            instr_ready = rd[k];
            pcsrc       = ps[k];
            imm_ext     = im[k];
            @(negedge clk);
            chk($sformatf("row%0d_req", k), 32'(imem_req), 32'(rq[k]));
            chk($sformatf("row%0d_valid", k), 32'(instr_valid), 32'(vl[k]));
            chk($sformatf("row%0d_pc", k), pc, pv[k]);
            chk($sformatf("row%0d_mis", k), 32'(misaligned), 32'(ms[k]));
            if (rq[k]) chk($sformatf("row%0d_addr", k), imem_addr, pv[k]);
            if (vl[k]) chk($sformatf("row%0d_instr", k), instr, mem_word(pv[k]));
            if (k == 0) chk("wrap_addr0", b_addr, 32'hFFFF_FFFC);
            if (k == 2) begin
                chk("wrap_req2", 32'(b_req), 32'h1);
                chk("wrap_addr2", b_addr, 32'h0);
            end
        end

        // Leave HALT through reset, then reset again while an ack is in flight
        @(posedge clk); #1; rst = 1'b1; instr_ready = 1'b1; pcsrc = 1'b0; imm_ext = 32'h0;
        push(32'h00); push(32'h00);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk_reset("halt_exit");
        @(posedge clk); @(negedge clk);
        chk("restart_req", 32'(imem_req), 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        @(posedge clk); @(negedge clk);
        chk("restart_valid", 32'(instr_valid), 32'h1);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_addr", imem_addr, 32'h4);
        chk("pre_rst_req", 32'(imem_req), 32'h1);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk_reset("mid_rst");
        @(posedge clk); @(negedge clk);
        chk("post_rst_req", 32'(imem_req), 32'h1);
        chk("post_rst_addr", imem_addr, 32'h0);
        @(posedge clk); @(negedge clk);
        chk("post_rst_valid", 32'(instr_valid), 32'h1);
        @(posedge clk); #1; instr_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I core, directly upstream of the control unit and decoder. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, registers the returned instruction and presents it to decode with a valid/ready handshake. It consumes the control unit's `PCsrc` and the sign-extended immediate to pick the next PC (`PC+4` or `PC+ImmExt`), and halts on a misaligned target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `PCsrc`  in  1  from control unit; 1 = take branch target.
- `ImmExt`  in  32  sign-extended branch offset for the instruction currently presented.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  word address of the request; equals `PC`.
- `imem_ack`  in  1  memory response valid; `imem_rdata` sampled this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  registered instruction to decode.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  decode/execute has consumed `instr` this cycle.
- `PC`  out  32  address of `instr`.
- `misaligned`  out  1  sticky; next PC had bits [1:0] ≠ 0; fetch halted.

## Operation
- State machine, states `IDLE`, `REQ`, `HOLD`, `HALT`.
- `IDLE`: entered on reset; leaves to `REQ` on the next cycle unconditionally.
- `REQ`: `imem_req`=1, `imem_addr`=`PC`, both stable until `imem_ack`. On `imem_ack`: `instr`←`imem_rdata`, go to `HOLD`.
- `HOLD`: `instr_valid`=1, `instr`/`PC` stable. On `instr_ready`: compute next = `PCsrc` ? `PC`+`ImmExt` : `PC`+4. If next[1:0]≠0: `misaligned`←1, go to `HALT`, `PC` unchanged. Else `PC`←next, go to `REQ`.
- `HALT`: no requests, `instr_valid`=0; only `rst` exits.
- `PCsrc`/`ImmExt` sampled only in the `HOLD` cycle where `instr_ready`=1; ignored otherwise.
- Arithmetic modulo 2^32: `PC`=32'hFFFF_FFFC with `PCsrc`=0 wraps to 0; negative `ImmExt` handled as two's complement.
- `imem_ack` outside `REQ` is ignored.
- `imem_req`, `instr_valid` are Moore outputs of state (no combinational path from inputs).

## Timing
- Reset values: `PC`=`RESET_PC`, `instr`=32'h0000_0013 (NOP), `instr_valid`=0, `imem_req`=0, `misaligned`=0, state `IDLE`.
- First request: `imem_req` high in the 2nd cycle after `rst` deasserts.
- Zero-wait memory (ack in first `REQ` cycle) with `instr_ready` tied high: one instruction per 2 cycles; `instr_valid` rises the cycle after ack.
- Ack to `instr_valid`: 1 cycle. `instr_ready` to new `imem_req`/`imem_addr`: 1 cycle.
- `rst` mid-transaction (any state): next edge forces reset values; an ack arriving in the reset cycle is discarded; `imem_req` low the cycle after.
- `rst` has priority over every other input.

## Structure
- Package `fetch_pkg`: `fetch_state_t` enum (`IDLE`,`REQ`,`HOLD`,`HALT`), `NOP_INSTR`=32'h0000_0013, `RESET_PC_DEFAULT`.
- One combinational sub-module `pc_next`: inputs `PC`, `ImmExt`, `PCsrc`; outputs `next_pc`, `next_misaligned`. FSM and registers stay in `fetch_unit`.

## Test plan
- Reset then zero-wait memory, `instr_ready`=1, `PCsrc`=0: `imem_addr` sequence 0x0,0x4,0x8; `instr_valid` every 2nd cycle; `instr` matches memory words.
- Memory ack delayed 3 cycles at addr 0x8: `imem_req`/`imem_addr`=0x8 held 3 cycles, `instr_valid` stays 0 until 1 cycle after ack.
- `instr_ready`=0 for 4 cycles in `HOLD`: `instr`, `PC` stable, no new request; then `PCsrc`=1, `ImmExt`=-8 at PC 0x10 → next request 0x08.
- Branch `PCsrc`=1, `ImmExt`=0x6 at PC 0x20: `misaligned`=1, `PC` stays 0x20, `imem_req` never reasserts until `rst`.
- `RESET_PC`=32'hFFFF_FFFC, `PCsrc`=0: second request address 0x0.
- `rst` pulsed while in `REQ` with ack same cycle: outputs return to reset values, `instr` = NOP, fetch restarts at `RESET_PC`.
